regfile_writeback_queue: RTL and testbench
==========================================

# regfile_writeback_queue

- Buffers register-file write requests from the multicycle datapath's late writers (load unit, multiplier).
- Drains them into the register file's single write port whenever the primary pipeline is not using that port.
- Reports, per read port, whether a read register still has a queued write, plus bypass data, so decode can stall or forward.
- Sits between the writeback mux and the register file write port (`RegWrite`/`WriteReg`/`WriteD`).

## Interface
- `DEPTH`, 4, queue entries; power of two, at least 2
- `DATA_W`, 32, write data width
- `ADDR_W`, 5, register address width
- `clk` input 1: single clock, all state on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: write request valid.
- `in_ready` output 1: queue can accept a request; equals `!full & !flush`; 0 while `rst_n` low.
- `in_rd` input `ADDR_W`: destination register.
- `in_data` input `DATA_W`: write data.
- `flush` input 1: synchronous squash of all queued entries.
- `wr_block` input 1: the primary pipeline owns the write port this cycle.
- `rf_we` output 1: register-file write enable.
- `rf_waddr` output `ADDR_W`: register-file write address.
- `rf_wdata` output `DATA_W`: register-file write data.
- `q_raddr1`, `q_raddr2` input `ADDR_W`: decode read addresses to check.
- `pend1`, `pend2` output 1: queued write pending for the matching address.
- `byp_data1`, `byp_data2` output `DATA_W`: data of the youngest matching entry. Present only with `WBQ_BYPASS_EN`.
- `count` output `$clog2(DEPTH)+1`: occupied entries.

## Operation
- **Push:**
  - Occurs at a rising edge when `in_valid & in_ready`.
  - Request with `in_rd == 0` completes the handshake but is discarded; no entry, `count` unchanged. This matches r0 being hardwired zero.
- **Drain:**
  - `rf_we = !empty & !wr_block & !flush`.
  - `rf_waddr`/`rf_wdata` show the head entry. They are 0 when empty.
  - The head pops at the same edge the register file writes it.
  - Drain is strictly FIFO order; one entry per cycle maximum.
- **Simultaneous push and pop:** both happen; `count` unchanged.
- **Full:** `in_ready` = 0; the producer holds `in_valid`/`in_rd`/`in_data` stable until accepted.
- **Flush:**
  - Has priority over push and pop.
  - All entries are invalidated at the edge; pointers and `count` go to 0.
  - `rf_we` and `in_ready` are 0 during the flush cycle.
- **Lookup:**
  - `pendN` = some valid entry has `rd == q_raddrN`, with `q_raddrN != 0`.
  - Purely combinational over stored entries.
  - The same-cycle `in_*` request is NOT included.
  - The head entry being drained this cycle still counts as pending.
- **Pointers:** wrap modulo `DEPTH`; `count` distinguishes full from empty.

## Timing
- **Reset (async):** `count` 0, `rf_we` 0, `rf_waddr`/`rf_wdata` 0, `pendN` 0, `byp_dataN` 0, `in_ready` 0. `in_ready` rises to 1 in the first cycle after deassertion.
- **Latency:** a request accepted at edge N into an empty queue drives `rf_we`=1 during cycle N+1 and is written at edge N+1, if `wr_block` is low.
- **Throughput:** one push plus one drain per cycle.
- **Reset asserted mid-drain:** `rf_we` drops immediately; all queued writes are lost.
- **Timing path:** no combinational path from `in_*` to `rf_*`. Lookup outputs depend combinationally only on `q_raddrN` and stored state.

## Configuration
- **With `WBQ_BYPASS_EN` defined:**
  - `byp_data1`/`byp_data2` ports exist.
  - They carry the data of the youngest matching entry; 0 when no match.
  - Decode forwards instead of stalling.
- **Without the macro:**
  - The ports and the youngest-match priority logic are omitted.
  - Only `pendN` is produced; decode stalls on pending.

## Structure
- **Package `wbq_pkg`:**
  - `REG_ADDR_W` = 5 and `REG_DATA_W` = 32.
  - Packed struct `wbq_entry_t` holding `rd` and `data`.
  - Zero-register constant `REG_ZERO` = 0.
- **Sub-module `wbq_match`:**
  - One instance per read port.
  - Inputs: entry array, valid bits, head pointer, address.
  - Produces `pend` and, under the macro, youngest-match data.
  - Searches from the tail backwards.

## Test plan
- **Single write:** reset, push rd=5/0xDEADBEEF with `wr_block`=0 → next cycle `rf_we`=1, `rf_waddr`=5, `rf_wdata`=0xDEADBEEF; following cycle `rf_we`=0, `count`=0.
- **Fill and drain:**
  - Hold `wr_block`=1 and push rd=1..5 (data 0x10..0x50) → `count`=4, `in_ready`=0, 5th request held.
  - Release `wr_block` → writes rd 1,2,3,4,5 on consecutive cycles, in order.
- **Register zero:** push rd=0/0x1 → handshake completes, `count` stays 0, `rf_we` never asserts.
- **Lookup and bypass:**
  - With `wr_block`=1, push rd=7/0x11 then rd=7/0x22.
  - Set `q_raddr1`=7 → `pend1`=1, `byp_data1`=0x22 (macro on).
  - `q_raddr2`=0 → `pend2`=0.
  - After both drain → `pend1`=0.
- **Flush:** 3 entries queued, assert `flush` with `in_valid`=1 → `in_ready`=0, `rf_we`=0 that cycle; next cycle `count`=0, no write ever issued.
- **Reset mid-drain:** pull `rst_n` low while `rf_we`=1 with 2 entries → `rf_we`=0 and `count`=0 without waiting for a clock edge; after release the queue is empty and `in_ready`=1.

Source files
------------

// File: rtl/wbq_pkg.sv
// Shared types and constants for the register-file writeback queue.
// An entry carries one late register write: destination register plus data.
package wbq_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_DATA_W-1:0] data;
  } wbq_entry_t;

endpackage

// File: rtl/wbq_match.sv
// Per-read-port lookup over the queued writes: pending flag and, with
// WBQ_BYPASS_EN defined, the data of the youngest matching entry.
module wbq_match
  import wbq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  wbq_entry_t [DEPTH-1:0] i_entries,
  input  logic [DEPTH-1:0]       i_valid,
  input  logic [PTR_W-1:0]       i_head,
  input  logic [REG_ADDR_W-1:0]  i_addr,
  output logic                   o_pend
`ifdef WBQ_BYPASS_EN
  ,
  output logic [REG_DATA_W-1:0]  o_data
`endif
);

  logic [PTR_W-1:0] w_slot [DEPTH];
  logic [DEPTH-1:0] w_age_hit;

  // Hits are indexed by age: position 0 is the head (oldest), DEPTH-1 the youngest slot.
  for (genvar k = 0; k < DEPTH; k++) begin : g_age
    assign w_slot[k]    = i_head + PTR_W'(k);
    assign w_age_hit[k] = i_valid[w_slot[k]] &&
                          (i_entries[w_slot[k]].rd == i_addr) &&
                          (i_addr != REG_ZERO);
  end

  assign o_pend = |w_age_hit;

`ifdef WBQ_BYPASS_EN
  logic w_found;

  // Walk from the tail end back toward the head so the youngest write wins.
  always_comb begin
    o_data  = '0;
    w_found = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (!w_found && w_age_hit[k]) begin
        o_data  = i_entries[w_slot[k]].data;
        w_found = 1'b1;
      end
    end
  end
`else
  logic [REG_DATA_W-1:0] w_unused_data;

  always_comb begin
    w_unused_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_unused_data = w_unused_data ^ i_entries[i].data;
    end
  end
`endif

endmodule

// File: rtl/regfile_writeback_queue.sv
// Queue of late register-file writes drained into the single RF write port
// when the main pipeline leaves it idle. WBQ_BYPASS_EN adds byp_data1/2 ports.
module regfile_writeback_queue
  import wbq_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_rd,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     flush,
  input  logic                     wr_block,
  output logic                     rf_we,
  output logic [ADDR_W-1:0]        rf_waddr,
  output logic [DATA_W-1:0]        rf_wdata,
  input  logic [ADDR_W-1:0]        q_raddr1,
  input  logic [ADDR_W-1:0]        q_raddr2,
  output logic                     pend1,
  output logic                     pend2,
  output logic [$clog2(DEPTH):0]   count
`ifdef WBQ_BYPASS_EN
  ,
  output logic [DATA_W-1:0]        byp_data1,
  output logic [DATA_W-1:0]        byp_data2
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wbq_entry_t [DEPTH-1:0] r_mem;
  logic [DEPTH-1:0]       r_valid;
  logic [PTR_W-1:0]       r_head;
  logic [PTR_W-1:0]       r_tail;
  logic [CNT_W-1:0]       r_count;
  logic                   r_live;

  logic       w_empty;
  logic       w_full;
  logic       w_push;
  logic       w_pop;
  wbq_entry_t w_head_entry;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign in_ready = r_live & ~w_full & ~flush;

  // Writes to r0 complete the handshake but never occupy a slot.
  assign w_push = in_valid & in_ready & (in_rd != ADDR_W'(REG_ZERO));

  assign rf_we        = ~w_empty & ~wr_block & ~flush;
  assign w_pop        = rf_we;
  assign w_head_entry = r_mem[r_head];
  assign rf_waddr     = w_empty ? '0 : ADDR_W'(w_head_entry.rd);
  assign rf_wdata     = w_empty ? '0 : DATA_W'(w_head_entry.data);
  assign count        = r_count;

  // r_live holds in_ready low until the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live  <= 1'b0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      r_live <= 1'b1;
      if (flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
        r_valid <= '0;
      end else begin
        if (w_push) begin
          r_tail <= r_tail + PTR_W'(1);
        end
        if (w_pop) begin
          r_head <= r_head + PTR_W'(1);
        end
        r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        r_valid <= (r_valid | (DEPTH'(w_push) << r_tail)) &
                   ~(DEPTH'(w_pop) << r_head);
      end
    end
  end

  // Payload storage needs no reset; r_valid and r_count qualify every read of it.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_tail] <= '{rd: REG_ADDR_W'(in_rd), data: REG_DATA_W'(in_data)};
    end
  end

`ifdef WBQ_BYPASS_EN
  logic [REG_DATA_W-1:0] w_byp1;
  logic [REG_DATA_W-1:0] w_byp2;

  assign byp_data1 = DATA_W'(w_byp1);
  assign byp_data2 = DATA_W'(w_byp2);
`endif

  wbq_match #(
    .DEPTH (DEPTH)
  ) u_match1 (
    .i_entries (r_mem),
    .i_valid   (r_valid),
    .i_head    (r_head),
    .i_addr    (REG_ADDR_W'(q_raddr1)),
    .o_pend    (pend1)
`ifdef WBQ_BYPASS_EN
    ,
    .o_data    (w_byp1)
`endif
  );

  wbq_match #(
    .DEPTH (DEPTH)
  ) u_match2 (
    .i_entries (r_mem),
    .i_valid   (r_valid),
    .i_head    (r_head),
    .i_addr    (REG_ADDR_W'(q_raddr2)),
    .o_pend    (pend2)
`ifdef WBQ_BYPASS_EN
    ,
    .o_data    (w_byp2)
`endif
  );

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Scoreboard bench for regfile_writeback_queue: stimulus queues expected RF
// writes, a negedge monitor checks every presented write against them.
module tb_regfile_writeback_queue;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } expWrite_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_rd;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic              wr_block;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [ADDR_W-1:0] q_raddr1;
  logic [ADDR_W-1:0] q_raddr2;
  logic              pend1;
  logic              pend2;
  logic [2:0]        count;
`ifdef WBQ_BYPASS_EN
  logic [DATA_W-1:0] byp_data1;
  logic [DATA_W-1:0] byp_data2;
`endif

  expWrite_t sb[$];
  int errors = 0;
  int checks = 0;

  regfile_writeback_queue #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_rd     (in_rd),
    .in_data   (in_data),
    .flush     (flush),
    .wr_block  (wr_block),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .q_raddr1  (q_raddr1),
    .q_raddr2  (q_raddr2),
    .pend1     (pend1),
    .pend2     (pend2),
    .count     (count)
`ifdef WBQ_BYPASS_EN
    ,
    .byp_data1 (byp_data1),
    .byp_data2 (byp_data2)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] rd, input logic [31:0] d,
                               input logic wb, input logic fl);
    in_valid = v;
    in_rd    = rd;
    in_data  = d;
    wr_block = wb;
    flush    = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a request and holds it until the handshake edge, bounded.
  task automatic pushWhenReady(input logic [4:0] rd, input logic [31:0] d, input logic wb);
    bit done = 1'b0;
    step();
    applyStimulus(1'b1, rd, d, wb, 1'b0);
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
    end
    if (!done) checkOutput("pushTimeout", 32'(in_ready), 32'd1);
    step();
    applyStimulus(1'b0, 5'd0, 32'd0, wb, 1'b0);
  endtask

  // Monitor: every write the DUT presents must match the oldest expected one.
  initial begin
    forever begin
      @(negedge clk);
      if (rf_we) begin
        if (sb.size() == 0) begin
          checkOutput("unexpectedWrite", 32'(rf_we), 32'd0);
        end else begin
          expWrite_t e;
          e = sb.pop_front();
          checkOutput("drainAddr", 32'(rf_waddr), 32'(e.rd));
          checkOutput("drainData", rf_wdata, e.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n    = 1'b1;
    q_raddr1 = 5'd5;
    q_raddr2 = 5'd0;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    $display("[TB] reset state");
    checkOutput("rstCount", 32'(count), 32'd0);
    checkOutput("rstRfWe", 32'(rf_we), 32'd0);
    checkOutput("rstRfWaddr", 32'(rf_waddr), 32'd0);
    checkOutput("rstRfWdata", rf_wdata, 32'd0);
    checkOutput("rstInReady", 32'(in_ready), 32'd0);
    checkOutput("rstPend1", 32'(pend1), 32'd0);
`ifdef WBQ_BYPASS_EN
    checkOutput("rstByp1", byp_data1, 32'd0);
`endif
    #9 rst_n = 1'b1;

    $display("[TB] single write");
    step();
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0);
    sb.push_back('{rd: 5'd5, data: 32'hDEADBEEF});
    @(negedge clk);
    checkOutput("singleReady", 32'(in_ready), 32'd1);
    checkOutput("singleCountBefore", 32'(count), 32'd0);
    checkOutput("singlePendSameCycle", 32'(pend1), 32'd0);
    step();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("singleRfWe", 32'(rf_we), 32'd1);
    checkOutput("singleCount", 32'(count), 32'd1);
    checkOutput("singlePendHead", 32'(pend1), 32'd1);
    step();
    @(negedge clk);
    checkOutput("singleRfWeAfter", 32'(rf_we), 32'd0);
    checkOutput("singleCountAfter", 32'(count), 32'd0);
    checkOutput("singlePendAfter", 32'(pend1), 32'd0);

    $display("[TB] fill and drain");
    for (int i = 1; i <= 4; i++) begin
      pushWhenReady(5'(i), 32'(16 * i), 1'b1);
      sb.push_back('{rd: 5'(i), data: 32'(16 * i)});
    end
    step();
    applyStimulus(1'b1, 5'd5, 32'h50, 1'b1, 1'b0);
    sb.push_back('{rd: 5'd5, data: 32'h50});
    @(negedge clk);
    checkOutput("fullCount", 32'(count), 32'd4);
    checkOutput("fullReady", 32'(in_ready), 32'd0);
    step();
    @(negedge clk);
    checkOutput("fullHeldCount", 32'(count), 32'd4);
    checkOutput("fullBlockedWe", 32'(rf_we), 32'd0);
    pushWhenReady(5'd5, 32'h50, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("drainBurst", 32'(rf_we), 32'd1);
    end
    @(negedge clk);
    checkOutput("drainDoneWe", 32'(rf_we), 32'd0);
    checkOutput("drainDoneCount", 32'(count), 32'd0);

    $display("[TB] register zero");
    pushWhenReady(5'd0, 32'h1, 1'b0);
    @(negedge clk);
    checkOutput("zeroCount", 32'(count), 32'd0);
    checkOutput("zeroRfWe", 32'(rf_we), 32'd0);
    @(negedge clk);
    checkOutput("zeroRfWeLater", 32'(rf_we), 32'd0);

    $display("[TB] lookup and bypass");
    q_raddr1 = 5'd7;
    q_raddr2 = 5'd0;
    pushWhenReady(5'd7, 32'h11, 1'b1);
    sb.push_back('{rd: 5'd7, data: 32'h11});
    pushWhenReady(5'd7, 32'h22, 1'b1);
    sb.push_back('{rd: 5'd7, data: 32'h22});
    @(negedge clk);
    checkOutput("lookPend1", 32'(pend1), 32'd1);
    checkOutput("lookPend2Zero", 32'(pend2), 32'd0);
    checkOutput("lookCount", 32'(count), 32'd2);
`ifdef WBQ_BYPASS_EN
    checkOutput("lookByp1Youngest", byp_data1, 32'h22);
    checkOutput("lookByp2None", byp_data2, 32'd0);
`endif
    step();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("lookPendDraining", 32'(pend1), 32'd1);
    step();
    @(negedge clk);
    checkOutput("lookPendLast", 32'(pend1), 32'd1);
`ifdef WBQ_BYPASS_EN
    checkOutput("lookBypLast", byp_data1, 32'h22);
`endif
    step();
    @(negedge clk);
    checkOutput("lookPendCleared", 32'(pend1), 32'd0);
    checkOutput("lookCountCleared", 32'(count), 32'd0);

    $display("[TB] flush");
    q_raddr1 = 5'd2;
    pushWhenReady(5'd1, 32'hA, 1'b1);
    pushWhenReady(5'd2, 32'hB, 1'b1);
    pushWhenReady(5'd3, 32'hC, 1'b1);
    step();
    applyStimulus(1'b1, 5'd4, 32'hD, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("flushReady", 32'(in_ready), 32'd0);
    checkOutput("flushRfWe", 32'(rf_we), 32'd0);
    checkOutput("flushCountBefore", 32'(count), 32'd3);
    checkOutput("flushPendBefore", 32'(pend1), 32'd1);
    step();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("flushCountAfter", 32'(count), 32'd0);
    checkOutput("flushRfWeAfter", 32'(rf_we), 32'd0);
    checkOutput("flushPendAfter", 32'(pend1), 32'd0);
    @(negedge clk);
    checkOutput("flushRfWeLater", 32'(rf_we), 32'd0);

    $display("[TB] reset mid-drain");
    pushWhenReady(5'd9, 32'h99, 1'b1);
    pushWhenReady(5'd10, 32'hAA, 1'b1);
    sb.push_back('{rd: 5'd9, data: 32'h99});
    step();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("midRfWe", 32'(rf_we), 32'd1);
    checkOutput("midCount", 32'(count), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("asyncRfWe", 32'(rf_we), 32'd0);
    checkOutput("asyncCount", 32'(count), 32'd0);
    checkOutput("asyncRfWaddr", 32'(rf_waddr), 32'd0);
    checkOutput("asyncReady", 32'(in_ready), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    @(negedge clk);
    checkOutput("postRstReady", 32'(in_ready), 32'd1);
    checkOutput("postRstCount", 32'(count), 32'd0);
    checkOutput("postRstRfWe", 32'(rf_we), 32'd0);

    checkOutput("scoreboardEmpty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
